// File: rtl/pio_pkg.sv
// Shared definitions for the parallel I/O peripheral: register addresses,
// edge-capture modes and the per-bit edge-detect helper.
// Build option: PIO_DEBOUNCE_EN (see pio_debounce) does not affect this file.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_OUT  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // True when the debounced bit moved in the direction selected by mode.
  function automatic logic edge_hit(edge_mode_e mode, logic cur, logic prev);
    case (mode)
      EDGE_FALL: return prev & ~cur;
      EDGE_BOTH: return prev ^ cur;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: two-flop synchroniser followed by an optional
// stability filter (built only when PIO_DEBOUNCE_EN is defined).
// Latency: 2 cycles sync, plus DB_CYCLES cycles filter when enabled.
module pio_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic db_o
);

  logic s1_q, s2_q;

  // Values below 2 leave no room for a counter; this block only anchors the check.
  if (DB_CYCLES < 2) begin : g_db_cycles_unsupported
  end

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Count consecutive cycles the synchronised bit differs from the accepted
  // value; any return to agreement restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;
`else
  assign db_o = s2_q;
`endif

endmodule

// File: rtl/pio_ctrl_gen2.sv
// Avalon-MM parallel I/O: output register with set/clear, conditioned inputs
// with per-bit edge capture and a maskable level irq. Read latency 1, no waitrequest.
// Build option: PIO_DEBOUNCE_EN enables the per-bit debounce filter.
module pio_ctrl_gen2
  import pio_pkg::*;
#(
  parameter int               OUT_W     = 8,
  parameter int               IN_W      = 8,
  parameter int               DB_CYCLES = 50000,
  parameter int               EDGE_MODE = 0,
  parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  input  logic [IN_W-1:0]  pio_in,
  output logic [OUT_W-1:0] pio_out,
  output logic             irq
);

  localparam edge_mode_e MODE = (EDGE_MODE == 1) ? EDGE_FALL :
                                (EDGE_MODE == 2) ? EDGE_BOTH : EDGE_RISE;

  logic [IN_W-1:0]  db, db_prev_q, hit;
  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  mask_q, mask_d, edge_q, edge_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvld_q, irq_q, irq_d;
  logic             wr_out, wr_set, wr_clr, wr_mask, wr_edge;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < IN_W; i++) begin : g_bit
    pio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i (clk_clk),
      .rst_ni(reset_reset_n),
      .din_i (pio_in[i]),
      .db_o  (db[i])
    );
  end

  assign wr_out  = avs_write && (avs_address == ADDR_OUT);
  assign wr_set  = avs_write && (avs_address == ADDR_SET);
  assign wr_clr  = avs_write && (avs_address == ADDR_CLR);
  assign wr_mask = avs_write && (avs_address == ADDR_MASK);
  assign wr_edge = avs_write && (avs_address == ADDR_EDGE);

  // Per-bit edge detect against the previous debounced value.
  always_comb begin
    hit = '0;
    for (int i = 0; i < IN_W; i++) begin
      hit[i] = edge_hit(MODE, db[i], db_prev_q[i]);
    end
  end

  // Register-file next state; a fresh edge overrides a same-cycle W1C.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    if (wr_out) begin
      out_d = avs_writedata[OUT_W-1:0];
    end else if (wr_set) begin
      out_d = out_q | avs_writedata[OUT_W-1:0];
    end else if (wr_clr) begin
      out_d = out_q & ~avs_writedata[OUT_W-1:0];
    end
    if (wr_mask) begin
      mask_d = avs_writedata[IN_W-1:0];
    end
    edge_d = (edge_q & ~(wr_edge ? avs_writedata[IN_W-1:0] : '0)) | hit;
    irq_d  = |(edge_q & mask_q);
  end

  // Read mux samples pre-write contents; unmapped and write-only words read 0.
  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA: rdata_d[IN_W-1:0]  = db;
        ADDR_OUT:  rdata_d[OUT_W-1:0] = out_q;
        ADDR_MASK: rdata_d[IN_W-1:0]  = mask_q;
        ADDR_EDGE: rdata_d[IN_W-1:0]  = edge_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  // All architectural state, cleared asynchronously.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q     <= OUT_RESET;
      mask_q    <= '0;
      edge_q    <= '0;
      db_prev_q <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      db_prev_q <= db;
      rdata_q   <= rdata_d;
      rvld_q    <= avs_read;
      irq_q     <= irq_d;
    end
  end

  assign pio_out           = out_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvld_q;
  assign irq               = irq_q;

endmodule
